// File: rtl/fp_add_arbiter_pkg.sv
// Shared types for the floating-point adder arbiter: operand format,
// adder result-state encoding and the flush/drain FSM states.
package float_struct;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
  } float_point_num;

  typedef enum logic [1:0] {
    RES_OK  = 2'b00,
    RES_NAN = 2'b01,
    RES_INF = 2'b10,
    RES_NUL = 2'b11
  } res_state_e;

  typedef enum logic [1:0] {
    ARB_RUN   = 2'd0,
    ARB_DRAIN = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester-side bus of the adder arbiter: operand handshake in,
// one-hot response strobe plus shared result out.
interface fp_add_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import float_struct::*;

  logic           [NUM_REQ-1:0] req_vld;
  float_point_num [NUM_REQ-1:0] req_a;
  float_point_num [NUM_REQ-1:0] req_b;
  logic           [NUM_REQ-1:0] req_rdy;
  logic           [NUM_REQ-1:0] rsp_vld;
  float_point_num               rsp_data;
  logic           [1:0]         rsp_state;

  modport master (
    output req_vld, req_a, req_b,
    input  req_rdy, rsp_vld, rsp_data, rsp_state
  );

  modport slave (
    input  req_vld, req_a, req_b,
    output req_rdy, rsp_vld, rsp_data, rsp_state
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, searching cyclically; returns one-hot grant and winner index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_id
);

  logic w_found;

  // NOTE: every output gets a default before the loop so no latch is
  // inferred, and blocking '=' is used because later iterations read w_found.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(i_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[idx]) begin
        w_found      = 1'b1;
        o_grant[idx] = 1'b1;
        o_id         = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shift_reg_base.sv
// Fixed-depth shift register; the output is the oldest stage.
module shift_reg_base #(
  parameter int STAGES = 7,
  parameter int WIDTH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [STAGES];

  // NOTE: this array carries valid bits, so unlike a data RAM it must be
  // cleared on reset; '<=' keeps every stage reading last cycle's neighbour.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) r_pipe[s] <= '0;
    end else if (en) begin
      r_pipe[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

  assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one fixed-latency pipelined FP adder between NUM_REQ requesters,
// routing each result back by a tag that travels alongside the adder.
module fp_add_arbiter
  import float_struct::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 6,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  fp_add_arbiter_if.slave    req_if,
  output float_point_num     add_a,
  output float_point_num     add_b,
  output logic               add_vld,
  input  float_point_num     add_result,
  input  logic [1:0]         add_state,
  input  logic               flush,
  output logic               flush_done,
  output logic               busy
);

  localparam int CNT_W = $clog2(ADD_LAT + 3);
  localparam int TAG_W = ID_W + 1;

  localparam logic [1:0] S_RUN   = ARB_RUN;
  localparam logic [1:0] S_DRAIN = ARB_DRAIN;
  localparam logic [1:0] S_DONE  = ARB_DONE;

  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_grant_en;
  logic [NUM_REQ-1:0] w_req_masked;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_winner;
  logic               w_xfer;
  logic [TAG_W-1:0]   w_tag_in;
  logic [TAG_W-1:0]   w_tag_out;
  logic               w_tag_vld;
  logic [ID_W-1:0]    w_tag_id;
  float_point_num     r_add_a;
  float_point_num     r_add_b;
  logic               r_add_vld;
  logic [NUM_REQ-1:0] r_rsp_vld;
  float_point_num     r_rsp_data;
  logic [1:0]         r_rsp_state;

  // Grants are suppressed in the very cycle flush is first seen.
  assign w_grant_en   = (r_state == S_RUN) && !flush && !rst;
  assign w_req_masked = w_grant_en ? req_if.req_vld : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req   (w_req_masked),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_winner)
  );

  assign w_xfer         = |w_grant;
  assign req_if.req_rdy = w_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_vld <= 1'b0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_ptr     <= '0;
    end else begin
      r_add_vld <= w_xfer;
      if (w_xfer) begin
        r_add_a <= req_if.req_a[w_winner];
        r_add_b <= req_if.req_b[w_winner];
        r_ptr   <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      end
    end
  end

  // Stage 0 lines up with add_vld; the last stage lines up with add_result.
  assign w_tag_in = {w_xfer, w_winner};

  shift_reg_base #(.STAGES(ADD_LAT + 1), .WIDTH(TAG_W)) u_tag_pipe (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .i_d (w_tag_in),
    .o_q (w_tag_out)
  );

  assign {w_tag_vld, w_tag_id} = w_tag_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld   <= '0;
      r_rsp_data  <= '0;
      r_rsp_state <= '0;
    end else begin
      r_rsp_vld <= w_tag_vld ? (NUM_REQ'(1) << w_tag_id) : '0;
      if (w_tag_vld) begin
        r_rsp_data  <= add_result;
        r_rsp_state <= add_state;
      end
    end
  end

  // Counts from transfer until the response strobe has been presented.
  assign w_cnt_nxt = r_cnt + CNT_W'(w_xfer) - CNT_W'(|r_rsp_vld);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_state <= S_RUN;
    end else begin
      r_cnt <= w_cnt_nxt;
      case (r_state)
        S_RUN:   if (flush)            r_state <= S_DRAIN;
        S_DRAIN: if (w_cnt_nxt == '0)  r_state <= S_DONE;
        S_DONE:  if (!flush)           r_state <= S_RUN;
        default:                       r_state <= S_RUN;
      endcase
    end
  end

  assign add_a              = r_add_a;
  assign add_b              = r_add_b;
  assign add_vld            = r_add_vld;
  assign req_if.rsp_vld     = r_rsp_vld;
  assign req_if.rsp_data    = r_rsp_data;
  assign req_if.rsp_state   = r_rsp_state;
  assign flush_done         = (r_state == S_DONE);
  assign busy               = (r_cnt != '0);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a behavioural fixed-latency adder
// (positive normal operands only; exp=0xFF yields +inf with state INF).
module tb_fp_add_arbiter;
  import float_struct::*;

  localparam int NUM_REQ = 4;
  localparam int ADD_LAT = 6;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flush_done;
  logic busy;
  logic add_vld;
  logic [1:0] add_state;
  float_point_num add_a, add_b, add_result;

  always #5 clk = ~clk;

  fp_add_arbiter_if #(.NUM_REQ(NUM_REQ)) req_if ();

  fp_add_arbiter #(.NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_if     (req_if),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_vld    (add_vld),
    .add_result (add_result),
    .add_state  (add_state),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy)
  );

  function automatic logic [31:0] fp_add_model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb, et;
    logic [24:0] ma, mb, mt;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7F80_0000;
    ea = a[30:23]; eb = b[30:23];
    ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
    if (eb > ea) begin
      et = ea; ea = eb; eb = et;
      mt = ma; ma = mb; mb = mt;
    end
    mb = mb >> (ea - eb);
    ma = ma + mb;
    if (ma[24]) begin
      ma = ma >> 1;
      ea = ea + 8'd1;
    end
    return {1'b0, ea, ma[22:0]};
  endfunction

  function automatic logic [1:0] fp_state_model(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return RES_INF;
    return RES_OK;
  endfunction

  logic [31:0] m_res [ADD_LAT];
  logic [1:0]  m_st  [ADD_LAT];

  always @(posedge clk) begin
    m_res[0] <= fp_add_model(add_a, add_b);
    m_st[0]  <= fp_state_model(add_a, add_b);
    for (int k = 1; k < ADD_LAT; k++) begin
      m_res[k] <= m_res[k-1];
      m_st[k]  <= m_st[k-1];
    end
  end

  assign add_result = m_res[ADD_LAT-1];
  assign add_state  = m_st[ADD_LAT-1];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  int peak = 0;
  int g_id[$], g_cyc[$], r_id[$], r_cyc[$];
  logic [31:0] r_data[$];
  logic [1:0]  r_st[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_if.req_rdy[i] && req_if.req_vld[i]) begin
          g_id.push_back(i);
          g_cyc.push_back(cyc);
        end
        if (req_if.rsp_vld[i]) begin
          r_id.push_back(i);
          r_cyc.push_back(cyc);
          r_data.push_back(req_if.rsp_data);
          r_st.push_back(req_if.rsp_state);
        end
      end
      if (int'(u_dut.r_cnt) > peak) peak = int'(u_dut.r_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete(); r_id.delete(); r_cyc.delete();
    r_data.delete(); r_st.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_add_vld"},    add_vld,          1'b0);
    check({tag, "_add_a"},      add_a,            32'h0);
    check({tag, "_add_b"},      add_b,            32'h0);
    check({tag, "_rsp_vld"},    req_if.rsp_vld,   4'b0000);
    check({tag, "_rsp_data"},   req_if.rsp_data,  32'h0);
    check({tag, "_rsp_state"},  req_if.rsp_state, 2'b00);
    check({tag, "_req_rdy"},    req_if.req_rdy,   4'b0000);
    check({tag, "_busy"},       busy,             1'b0);
    check({tag, "_flush_done"}, flush_done,       1'b0);
  endtask

  logic [31:0] exp_sum [NUM_REQ];
  int          exp_order [9];
  int          done_cyc;

  initial begin
    exp_sum   = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3FC0_0000};
    exp_order = '{3, 0, 1, 2, 3, 0, 1, 2, 3};

    rst = 1'b1; flush = 1'b0;
    req_if.req_vld = '0; req_if.req_a = '0; req_if.req_b = '0;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Single op on requester 2: 1.0 + 2.0
    req_if.req_a[2] = 32'h3F80_0000; req_if.req_b[2] = 32'h4000_0000;
    req_if.req_vld  = 4'b0100;
    #2 check("t1_grant", req_if.req_rdy, 4'b0100);
    tick();
    req_if.req_vld = '0;
    check("t1_add_vld", add_vld, 1'b1);
    check("t1_add_a", add_a, 32'h3F80_0000);
    check("t1_add_b", add_b, 32'h4000_0000);
    check("t1_busy", busy, 1'b1);
    repeat (6) tick();
    check("t1_rsp_early", req_if.rsp_vld, 4'b0000);
    tick();
    check("t1_rsp_vld", req_if.rsp_vld, 4'b0100);
    check("t1_rsp_data", req_if.rsp_data, 32'h4040_0000);
    check("t1_rsp_state", req_if.rsp_state, 2'b00);
    tick();
    check("t1_rsp_off", req_if.rsp_vld, 4'b0000);
    check("t1_idle", busy, 1'b0);

    // Pointer now at 3: one op on 3, then all four valid for 8 cycles
    for (int i = 0; i < NUM_REQ; i++) req_if.req_a[i] = 32'h3F80_0000;
    req_if.req_b[0] = 32'h3F80_0000; req_if.req_b[1] = 32'h4000_0000;
    req_if.req_b[2] = 32'h4040_0000; req_if.req_b[3] = 32'h3F00_0000;
    clear_logs(); peak = 0;
    req_if.req_vld = 4'b1000;
    #2 check("t2_grant3", req_if.req_rdy, 4'b1000);
    tick();
    req_if.req_vld = 4'b1111;
    repeat (8) begin
      check("t2_busy", busy, 1'b1);
      tick();
    end
    req_if.req_vld = '0;
    repeat (12) tick();
    check("t2_grant_cnt", g_id.size(), 9);
    check("t2_rsp_cnt", r_id.size(), 9);
    for (int k = 0; k < 9 && k < g_id.size() && k < r_id.size(); k++) begin
      check("t2_grant_id", g_id[k], exp_order[k]);
      check("t2_rsp_id", r_id[k], exp_order[k]);
      check("t2_latency", r_cyc[k], g_cyc[k] + 8);
      check("t2_rsp_data", r_data[k], exp_sum[exp_order[k]]);
    end
    check("t2_peak_inflight", peak, 8);

    // Requester 1 alone, continuously for 5 cycles
    clear_logs();
    req_if.req_vld = 4'b0010;
    repeat (5) tick();
    req_if.req_vld = '0;
    repeat (12) tick();
    check("t3_grant_cnt", g_id.size(), 5);
    check("t3_rsp_cnt", r_id.size(), 5);
    for (int k = 0; k < 5 && k < g_id.size() && k < r_id.size(); k++) begin
      check("t3_grant_id", g_id[k], 1);
      check("t3_grant_cyc", g_cyc[k], g_cyc[0] + k);
      check("t3_rsp_id", r_id[k], 1);
      check("t3_latency", r_cyc[k], g_cyc[k] + 8);
      check("t3_rsp_data", r_data[k], 32'h4040_0000);
    end

    // Three ops, then flush: drain, DONE, resume
    clear_logs();
    req_if.req_vld = 4'b0001;
    repeat (3) tick();
    flush = 1'b1;
    req_if.req_vld = 4'b1111;
    repeat (8) begin
      #2;
      check("t4_no_grant", req_if.req_rdy, 4'b0000);
      check("t4_not_done", flush_done, 1'b0);
      tick();
    end
    #2;
    done_cyc = cyc;
    check("t4_rsp_cnt", r_id.size(), 3);
    if (r_cyc.size() == 3) check("t4_done_after_last", done_cyc, r_cyc[2] + 1);
    check("t4_flush_done", flush_done, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_no_grant_done", req_if.req_rdy, 4'b0000);
    tick();
    check("t4_hold_done", flush_done, 1'b1);
    tick();
    flush = 1'b0;
    #2;
    check("t4_done_exit_cycle", flush_done, 1'b1);
    check("t4_no_grant_exit", req_if.req_rdy, 4'b0000);
    tick();
    #2;
    check("t4_run", flush_done, 1'b0);
    check("t4_resume_grant", req_if.req_rdy, 4'b0010);
    tick();
    req_if.req_vld = '0;
    repeat (12) tick();

    // Four ops in flight, then a one-cycle reset
    clear_logs();
    req_if.req_vld = 4'b1111;
    repeat (4) tick();
    req_if.req_vld = '0;
    rst = 1'b1;
    tick();
    check_idle_outputs("t5_reset");
    rst = 1'b0;
    repeat (10) begin
      check("t5_no_rsp", req_if.rsp_vld, 4'b0000);
      tick();
    end
    check("t5_grant_cnt", g_id.size(), 4);
    check("t5_rsp_cnt", r_id.size(), 0);

    // Infinite operand on requester 0
    req_if.req_a[0] = 32'h7F80_0000; req_if.req_b[0] = 32'h3F80_0000;
    req_if.req_vld  = 4'b0001;
    #2 check("t6_grant", req_if.req_rdy, 4'b0001);
    tick();
    req_if.req_vld = '0;
    repeat (6) tick();
    check("t6_rsp_early", req_if.rsp_vld, 4'b0000);
    tick();
    check("t6_rsp_vld", req_if.rsp_vld, 4'b0001);
    check("t6_rsp_state", req_if.rsp_state, 2'b10);
    check("t6_rsp_data", req_if.rsp_data, 32'h7F80_0000);
    tick();
    check("t6_rsp_off", req_if.rsp_vld, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
